// File: rtl/axi_dac_jesd204_tx_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_dac_jesd204_tx_framer_if
// Purpose  : Bundles the DAC sample handshake and the JESD204 TX link-layer
//            beat bus of the framer into one interface.
// Signals  : dac_valid/dac_ready/dac_data - sample word handshake (2 samples
//            per lane per word)
//            tx_ready/tx_data/tx_somf      - link-layer beat bus
//            tx_underflow/underflow_count  - underflow pulse and saturating
//            count
// Modports : master - sample source / link consumer side
//            slave  - the framer
// Revision : 1.0 - initial release
// ============================================================================
interface axi_dac_jesd204_tx_framer_if #(
  parameter int NUM_LANES     = 1,
  parameter int CHANNEL_WIDTH = 16
);
  logic                                 dac_valid;
  logic                                 dac_ready;
  logic [NUM_LANES*CHANNEL_WIDTH*2-1:0] dac_data;
  logic                                 tx_ready;
  logic [NUM_LANES*32-1:0]              tx_data;
  logic                                 tx_somf;
  logic                                 tx_underflow;
  logic [15:0]                          underflow_count;

  modport master (
    output dac_valid, dac_data, tx_ready,
    input  dac_ready, tx_data, tx_somf, tx_underflow, underflow_count
  );

  modport slave (
    input  dac_valid, dac_data, tx_ready,
    output dac_ready, tx_data, tx_somf, tx_underflow, underflow_count
  );
endinterface
`default_nettype wire

// File: rtl/axi_dac_jesd204_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : axi_dac_jesd204_tx_framer
// Purpose  : Buffers DAC sample words in a 2-entry FIFO and packs them into
//            per-lane 32-bit JESD204 link-layer beats. Tracks the multiframe
//            position (tx_somf) and reports idle beats that follow real data
//            as underflows.
// Ports    : tx_clk     - link clock, only clock
//            tx_resetn  - asynchronous active-low reset
//            pattern_en - (DAC_JESD204_TX_PATTERN_EN only) ramp test pattern
//            bus        - axi_dac_jesd204_tx_framer_if.slave (sample handshake,
//                         link beat bus, underflow status)
// Options  : DAC_JESD204_TX_PATTERN_EN - when defined, adds pattern_en and the
//            ramp generator that replaces the FIFO path while it is high.
// Revision : 1.0 - initial release
// ============================================================================
module axi_dac_jesd204_tx_framer #(
  parameter int NUM_LANES     = 1,
  parameter int NUM_CHANNELS  = 1,
  parameter int CHANNEL_WIDTH = 16,
  parameter int BEATS_PER_MF  = 8
) (
  input  wire logic                    tx_clk,
  input  wire logic                    tx_resetn,
`ifdef DAC_JESD204_TX_PATTERN_EN
  input  wire logic                    pattern_en,
`endif
  axi_dac_jesd204_tx_framer_if.slave   bus
);

  localparam int c_dw      = NUM_LANES * CHANNEL_WIDTH * 2;
  localparam int c_nsmp    = NUM_LANES * 2;
  localparam int c_dpw     = (2 * NUM_LANES) / NUM_CHANNELS;
  localparam int c_h       = (c_dpw >= 4) ? (c_dpw / 4) : 1;
  localparam bit c_hd      = (NUM_LANES > NUM_CHANNELS);
  localparam int c_oct_off = c_hd ? 32 : 8;
  localparam int c_tail    = 16 - CHANNEL_WIDTH;
  localparam int c_cnt_w   = (BEATS_PER_MF > 1) ? $clog2(BEATS_PER_MF) : 1;

  // --------------------------------------------------------------------------
  // 2-entry FIFO
  // --------------------------------------------------------------------------
  logic [c_dw-1:0]          r_mem [2];
  logic [1:0]               r_count;
  logic                     r_rd_ptr;
  logic                     r_wr_ptr;
  logic                     w_pat_mode;
  logic                     w_push;
  logic                     w_pop;
  logic [c_dw-1:0]          w_head;
  logic [NUM_LANES*32-1:0]  w_pack;

`ifdef DAC_JESD204_TX_PATTERN_EN
  logic [15:0]              r_ramp;
  assign w_pat_mode = pattern_en;
`else
  assign w_pat_mode = 1'b0;
`endif

  // dac_ready depends only on registered occupancy, so it never combinationally
  // follows dac_valid or tx_ready.
  assign bus.dac_ready = (r_count != 2'd2) && !w_pat_mode;
  assign w_push        = bus.dac_valid && bus.dac_ready;
  // Pop looks at occupancy before this edge's push, so a word written into an
  // empty FIFO always spends at least one cycle in it.
  assign w_pop         = bus.tx_ready && (r_count != 2'd0) && !w_pat_mode;
  assign w_head        = r_mem[r_rd_ptr];

  always_ff @(posedge tx_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.dac_data;
    end
  end

  always_ff @(posedge tx_clk or negedge tx_resetn) begin
    if (!tx_resetn) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Octet packing: each sample is left-justified into 16 bits and split into
  // two octets. In the high-density layout (more lanes than channels) one
  // channel's samples are spread across lanes, so the octet pair lands 32 bits
  // apart instead of adjacent.
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < c_nsmp; k++) begin : g_slot
      localparam int c_i    = k / c_dpw;
      localparam int c_j    = k % c_dpw;
      localparam int c_lsb0 = c_hd ? ((c_i * c_h + c_j % c_h) * 64 + (c_j / c_h) * 8)
                                   : (k * 16);
      localparam int c_lsb1 = c_lsb0 + c_oct_off;

      logic [15:0] w_dac_word;
      logic [15:0] w_word;

      assign w_dac_word = 16'(w_head[k*CHANNEL_WIDTH +: CHANNEL_WIDTH]) << c_tail;

`ifdef DAC_JESD204_TX_PATTERN_EN
      logic [15:0] w_ramp_k;
      assign w_ramp_k = r_ramp + 16'(k);
      // Keep only the CHANNEL_WIDTH MSBs so the pattern looks like a real sample.
      assign w_word   = pattern_en ? 16'((w_ramp_k >> c_tail) << c_tail) : w_dac_word;
`else
      assign w_word   = w_dac_word;
`endif

      assign w_pack[c_lsb0 +: 8] = w_word[15:8];
      assign w_pack[c_lsb1 +: 8] = w_word[7:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Link beat register, multiframe counter and underflow tracking
  // --------------------------------------------------------------------------
  logic [NUM_LANES*32-1:0] r_tx_data;
  logic [c_cnt_w-1:0]      r_beat;
  logic                    r_armed;
  logic                    r_underflow;
  logic [15:0]             r_uf_cnt;

  always_ff @(posedge tx_clk or negedge tx_resetn) begin
    if (!tx_resetn) begin
      r_tx_data   <= '0;
      r_beat      <= '0;
      r_armed     <= 1'b0;
      r_underflow <= 1'b0;
      r_uf_cnt    <= 16'd0;
    end else begin
      r_underflow <= 1'b0;
      if (bus.tx_ready) begin
        // BEATS_PER_MF is a power of two, so natural wrap gives MF-1 -> 0.
        r_beat <= r_beat + c_cnt_w'(1);
        if (w_pat_mode) begin
          r_tx_data <= w_pack;
        end else if (r_count != 2'd0) begin
          r_tx_data <= w_pack;
          r_armed   <= 1'b1;
        end else begin
          // Idle beats before the first real word are start-up, not underflow.
          r_tx_data <= '0;
          if (r_armed) begin
            r_underflow <= 1'b1;
            if (r_uf_cnt != 16'hFFFF) begin
              r_uf_cnt <= r_uf_cnt + 16'd1;
            end
          end
        end
      end
    end
  end

`ifdef DAC_JESD204_TX_PATTERN_EN
  always_ff @(posedge tx_clk or negedge tx_resetn) begin
    if (!tx_resetn) begin
      r_ramp <= 16'd0;
    end else if (!pattern_en) begin
      r_ramp <= 16'd0;
    end else if (bus.tx_ready) begin
      r_ramp <= r_ramp + 16'(NUM_LANES * 2);
    end
  end
`endif

  assign bus.tx_data         = r_tx_data;
  assign bus.tx_somf         = (r_beat == '0);
  assign bus.tx_underflow    = r_underflow;
  assign bus.underflow_count = r_uf_cnt;

endmodule
`default_nettype wire
